// File: rtl/pipeline_pkg.sv
// Shared RV32I decode definitions for the ID stage: opcodes, operation classes and immediate formats.
package pipeline_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      OP      = 4'd0,
      OP_IMM  = 4'd1,
      LOAD    = 4'd2,
      STORE   = 4'd3,
      BRANCH  = 4'd4,
      JAL     = 4'd5,
      LUI     = 4'd6,
      ILLEGAL = 4'd7
   } op_class_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J,
      IMM_U
   } imm_fmt_e;

   // Anything outside the supported subset, including compressed encodings, becomes ILLEGAL.
   function automatic op_class_e classify(input logic [31:0] ir);
      op_class_e c;
      c = ILLEGAL;
      if (ir[1:0] == 2'b11) begin
         case (ir[6:0])
            OPC_OP:     c = OP;
            OPC_OP_IMM: c = OP_IMM;
            OPC_LOAD:   c = LOAD;
            OPC_STORE:  c = STORE;
            OPC_BRANCH: c = BRANCH;
            OPC_JAL:    c = JAL;
            OPC_LUI:    c = LUI;
            default:    c = ILLEGAL;
         endcase
      end
      return c;
   endfunction

   function automatic imm_fmt_e immFormat(input op_class_e op);
      imm_fmt_e f;
      case (op)
         OP_IMM, LOAD: f = IMM_I;
         STORE:        f = IMM_S;
         BRANCH:       f = IMM_B;
         JAL:          f = IMM_J;
         LUI:          f = IMM_U;
         default:      f = IMM_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/pipeline_stage_id_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle; slave is the ID stage, master the surrounding pipeline.
interface pipeline_stage_id_if;
   import pipeline_pkg::*;

   logic [31:0]     if_id_ir;
   logic [XLEN-1:0] if_id_pc;
   logic            if_id_valid;
   logic            id_ready;
   logic            ex_ready;
   logic            id_ex_valid;
   logic [XLEN-1:0] id_ex_pc;
   logic [XLEN-1:0] id_ex_rs1_val;
   logic [XLEN-1:0] id_ex_rs2_val;
   logic [XLEN-1:0] id_ex_imm;
   logic [4:0]      id_ex_rd;
   op_class_e       id_ex_op;
   logic [3:0]      id_ex_funct;

   modport master (
      output if_id_ir, if_id_pc, if_id_valid, ex_ready,
      input  id_ready, id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val,
             id_ex_imm, id_ex_rd, id_ex_op, id_ex_funct
   );

   modport slave (
      input  if_id_ir, if_id_pc, if_id_valid, ex_ready,
      output id_ready, id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val,
             id_ex_imm, id_ex_rd, id_ex_op, id_ex_funct
   );

endinterface

// File: rtl/pipeline_regfile.sv
// 32x32 register file, two async read ports and one write port; x0 reads zero.
// PIPELINE_ID_BYPASS_EN forwards a same-cycle write into the read ports.
module pipeline_regfile
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [4:0]      i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [4:0]      i_raddr1,
   output logic [XLEN-1:0] o_rdata1,
   input  logic [4:0]      i_raddr2,
   output logic [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic            w_hit1;
   logic            w_hit2;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

`ifdef PIPELINE_ID_BYPASS_EN
   assign w_hit1 = i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr1);
   assign w_hit2 = i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr2);
`else
   assign w_hit1 = 1'b0;
   assign w_hit2 = 1'b0;
`endif

   assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : (w_hit1 ? i_wdata : r_regs[i_raddr1]);
   assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : (w_hit2 ? i_wdata : r_regs[i_raddr2]);

endmodule

// File: rtl/pipeline_stage_id.sv
// RV32I-subset Instruction Decode stage with load-use interlock and a registered ID/EX stage.
// Without PIPELINE_ID_BYPASS_EN, ID also stalls while writeback targets a source register it needs.
module pipeline_stage_id
   import pipeline_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   pipeline_stage_id_if.slave bus,
   input  logic               flush,
   input  logic               wb_we,
   input  logic [4:0]         wb_rd,
   input  logic [XLEN-1:0]    wb_data
);

   logic [31:0]     w_ir;
   op_class_e       w_op;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic            w_rs1Used;
   logic            w_rs2Used;
   logic [XLEN-1:0] w_rdata1;
   logic [XLEN-1:0] w_rdata2;
   logic [XLEN-1:0] w_imm;
   logic            w_adv;
   logic            w_loadUse;
   logic            w_wbConflict;
   logic            w_ready;

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rs1Val;
   logic [XLEN-1:0] r_rs2Val;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rd;
   op_class_e       r_op;
   logic [3:0]      r_funct;

   assign w_ir      = bus.if_id_ir;
   assign w_op      = classify(w_ir);
   assign w_rs1     = w_ir[19:15];
   assign w_rs2     = w_ir[24:20];
   assign w_rs1Used = !((w_op == JAL) || (w_op == LUI));
   assign w_rs2Used = (w_op == OP) || (w_op == STORE) || (w_op == BRANCH);
   assign w_rd      = ((w_op == STORE) || (w_op == BRANCH) || (w_op == ILLEGAL)) ? 5'd0 : w_ir[11:7];

   pipeline_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_we),
      .i_waddr  (wb_rd),
      .i_wdata  (wb_data),
      .i_raddr1 (w_rs1),
      .o_rdata1 (w_rdata1),
      .i_raddr2 (w_rs2),
      .o_rdata2 (w_rdata2)
   );

   always_comb begin
      w_imm = '0;
      case (immFormat(w_op))
         IMM_I:   w_imm = {{20{w_ir[31]}}, w_ir[31:20]};
         IMM_S:   w_imm = {{20{w_ir[31]}}, w_ir[31:25], w_ir[11:7]};
         IMM_B:   w_imm = {{19{w_ir[31]}}, w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0};
         IMM_J:   w_imm = {{11{w_ir[31]}}, w_ir[31], w_ir[19:12], w_ir[20], w_ir[30:21], 1'b0};
         IMM_U:   w_imm = {w_ir[31:12], 12'h000};
         default: w_imm = '0;
      endcase
   end

   // A load still sitting in ID/EX cannot supply its result to the instruction behind it.
   assign w_adv     = !r_valid || bus.ex_ready;
   assign w_loadUse = r_valid && (r_op == LOAD) && (r_rd != 5'd0) &&
                      ((w_rs1Used && (r_rd == w_rs1)) || (w_rs2Used && (r_rd == w_rs2)));

`ifdef PIPELINE_ID_BYPASS_EN
   assign w_wbConflict = 1'b0;
`else
   assign w_wbConflict = wb_we && (wb_rd != 5'd0) &&
                         ((w_rs1Used && (wb_rd == w_rs1)) || (w_rs2Used && (wb_rd == w_rs2)));
`endif

   assign w_ready = rst ? 1'b0 : (flush ? 1'b1 : (w_adv && !w_loadUse && !w_wbConflict));

   // Flush kills ID/EX and swallows the fetch word; otherwise load on accept, bubble on stall, hold on backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_rs1Val <= '0;
         r_rs2Val <= '0;
         r_imm    <= '0;
         r_rd     <= '0;
         r_op     <= ILLEGAL;
         r_funct  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_adv) begin
         if (bus.if_id_valid && w_ready) begin
            r_valid  <= 1'b1;
            r_pc     <= bus.if_id_pc;
            r_rs1Val <= w_rs1Used ? w_rdata1 : '0;
            r_rs2Val <= w_rs2Used ? w_rdata2 : '0;
            r_imm    <= w_imm;
            r_rd     <= w_rd;
            r_op     <= w_op;
            r_funct  <= {w_ir[30], w_ir[14:12]};
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.id_ready      = w_ready;
   assign bus.id_ex_valid   = r_valid;
   assign bus.id_ex_pc      = r_pc;
   assign bus.id_ex_rs1_val = r_rs1Val;
   assign bus.id_ex_rs2_val = r_rs2Val;
   assign bus.id_ex_imm     = r_imm;
   assign bus.id_ex_rd      = r_rd;
   assign bus.id_ex_op      = r_op;
   assign bus.id_ex_funct   = r_funct;

endmodule
